// File: rtl/cmp_seq_unit.sv
// Sequential magnitude comparator: walks the operands CHUNK bits at a time,
// MSB slice first, and stops at the first differing slice. Signed compares
// are handled by flipping the operand MSBs at capture so that signed order
// maps onto unsigned order.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for a request, in_ready high
// S_COMPARE | comparing slice idx_q of the captured operands
// S_DONE    | result and flags held on the outputs until out_ready
module cmp_seq_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op_sel,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [3:0]        op_q, op_d;
    logic              eq_q, eq_d;
    logic              lt_q, lt_d;
    logic              gt_q, gt_d;
    logic              pred_q, pred_d;

    logic [CHUNK-1:0]  slice_a, slice_b;
    logic              slice_lt;

    function automatic logic pred_f(input logic [3:0] op, input logic e,
                                    input logic l, input logic g);
        logic p;
        case (op)
            4'b0111: p = e;
            4'b1001: p = !e;
            4'b1010: p = g;
            4'b1011: p = l;
            4'b1110: p = g | e;
            4'b1111: p = l | e;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Select the slice currently under comparison.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*CHUNK +: CHUNK];
                slice_b = b_q[i*CHUNK +: CHUNK];
            end
        end
        slice_lt = (slice_a < slice_b);
    end

    // Next-state logic: capture, slice walk with early exit, hold until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        pred_d  = pred_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = signed_mode ? (A ^ MSB_MASK) : A;
                    b_d     = signed_mode ? (B ^ MSB_MASK) : B;
                    op_d    = op_sel;
                    idx_d   = IDX_TOP;
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (slice_a != slice_b) begin
                    eq_d    = 1'b0;
                    lt_d    = slice_lt;
                    gt_d    = !slice_lt;
                    pred_d  = pred_f(op_q, 1'b0, slice_lt, !slice_lt);
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    pred_d  = pred_f(op_q, 1'b1, 1'b0, 1'b0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    eq_d    = 1'b0;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    pred_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            pred_q  <= pred_d;
        end
    end

    // Flags are only ever non-zero while in S_DONE, so they drive out directly.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        result    = WIDTH'(pred_q);
        eq        = eq_q;
        lt        = lt_q;
        gt        = gt_q;
    end

endmodule

// File: tb/tb_cmp_seq_unit.sv
module tb_cmp_seq_unit;
    localparam int W = 8;
    localparam int C = 2;
    localparam int N = W / C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   op_sel = '0;
    logic         signed_mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         eq, lt, gt;

    int errors = 0;
    int checks = 0;

    cmp_seq_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op_sel(op_sel), .signed_mode(signed_mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .eq(eq), .lt(lt), .gt(gt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: integer compare, latency from the first differing chunk of A^B.
    function automatic void model_eval(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] op, input logic sm,
                                       output int k, output bit e, output bit l,
                                       output bit g, output bit p);
        int ia, ib;
        if (sm) begin
            ia = $signed(a);
            ib = $signed(b);
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        e = (ia == ib);
        l = (ia < ib);
        g = (ia > ib);
        k = N;
        for (int i = 0; i < N; i++) begin
            if ((((int'(a ^ b)) >> (W - (i + 1) * C)) & ((1 << C) - 1)) != 0) begin
                k = i + 1;
                break;
            end
        end
        case (op)
            4'b0111: p = e;
            4'b1001: p = !e;
            4'b1010: p = g;
            4'b1011: p = l;
            4'b1110: p = g || e;
            4'b1111: p = l || e;
            default: p = 1'b0;
        endcase
    endfunction

    bit m_busy = 1'b0;
    bit m_valid = 1'b0;
    int m_wait = 0;
    bit m_e, m_l, m_g, m_p;

    // Every-cycle comparison against the model, then advance the model over the next edge.
    always @(negedge clk) begin
        int k;
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("result", 32'(result), m_valid ? 32'(m_p) : 32'd0);
        chk("eq", 32'(eq), m_valid ? 32'(m_e) : 32'd0);
        chk("lt", 32'(lt), m_valid ? 32'(m_l) : 32'd0);
        chk("gt", 32'(gt), m_valid ? 32'(m_g) : 32'd0);
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                model_eval(A, B, op_sel, signed_mode, k, m_e, m_l, m_g, m_p);
                m_busy = 1'b1;
                m_wait = k;
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic sm, input int exp_k, input logic [7:0] exp_res,
                       input logic e, input logic l, input logic g, input bit handshake);
        int lat;
        @(posedge clk);
        #1;
        A = a; B = b; op_sel = op; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        chk("latency", 32'(lat), 32'(exp_k));
        chk("lit_result", 32'(result), 32'(exp_res));
        chk("lit_eq", 32'(eq), 32'(e));
        chk("lit_lt", 32'(lt), 32'(l));
        chk("lit_gt", 32'(gt), 32'(g));
        if (handshake) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] ops [8];
        ops = '{4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b1111, 4'b0000, 4'b0101};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);

        txn(8'h80, 8'h7F, 4'b1010, 1'b0, 1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        txn(8'h5A, 8'h5A, 4'b0111, 1'b0, 4, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        txn(8'h5A, 8'h5A, 4'b1001, 1'b0, 4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        txn(8'hFF, 8'h01, 4'b1011, 1'b1, 1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        txn(8'hFF, 8'h01, 4'b1011, 1'b0, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        txn(8'h03, 8'h01, 4'b0000, 1'b0, 4, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        txn(8'h40, 8'h41, 4'b1110, 1'b0, 4, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        txn(8'h24, 8'h34, 4'b1111, 1'b0, 2, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1);
        txn(8'h80, 8'h7F, 4'b1010, 1'b1, 1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);

        // Backpressure with a competing request held on the inputs.
        txn(8'h80, 8'h7F, 4'b1010, 1'b0, 1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
        A = 8'h10; B = 8'h10; op_sel = 4'b0111; signed_mode = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_result", 32'(result), 32'h01);
            chk("bp_gt", 32'(gt), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accepted", 32'(in_ready), 32'd0);
        wait_valid(lat);
        chk("bp_second_latency", 32'(lat), 32'd4);
        chk("bp_second_result", 32'(result), 32'h01);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset on the second COMPARE edge.
        @(posedge clk);
        #1;
        A = 8'h12; B = 8'h13; op_sel = 4'b1011; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_lt", 32'(lt), 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("abort_no_valid", 32'(out_valid), 32'd0);
        end

        // Mixed operands, checked by the per-cycle model.
        out_ready = 1'b1;
        for (int t = 0; t < 25; t++) begin
            @(posedge clk);
            #1;
            A = 8'($urandom_range(0, 255));
            B = (t % 4 == 0) ? A : 8'($urandom_range(0, 255));
            op_sel = ops[$urandom_range(0, 7)];
            signed_mode = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_valid(lat);
            chk("rand_completes", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
